// File: rtl/pad_reset_sequencer.sv
// Board reset sequencer: synchronizes and debounces the reset button,
// waits for PLL lock, then stretches the release of the SoC reset.
module pad_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STRETCH_CYCLES  = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_rst_ni,
  input  logic       pll_locked_i,
  output logic       soc_rst_no,
  output logic [1:0] state_o,
  output logic [7:0] press_cnt_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    WAIT_LOCK = 2'b01,
    STRETCH   = 2'b10,
    RUN       = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] btn_ff;
  logic [SYNC_STAGES-1:0] lock_ff;
  logic                   btn_sync;
  logic                   lock_sync;
  logic                   btn_db;
  logic [DW-1:0]          db_cnt;
  logic                   db_fire;
  logic [SW-1:0]          st_cnt;
  logic                   run_ok;
  state_t                 state;
  state_t                 state_nxt;

  assign btn_sync  = btn_ff[SYNC_STAGES-1];
  assign lock_sync = lock_ff[SYNC_STAGES-1];
  assign db_fire   = (btn_sync != btn_db) && (db_cnt == DB_LAST);
  assign run_ok    = lock_sync && btn_db;
  assign state_o   = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_ff  <= '1;
      lock_ff <= '0;
    end else begin
      btn_ff  <= {btn_ff[SYNC_STAGES-2:0], btn_rst_ni};
      lock_ff <= {lock_ff[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  // Any sample matching the accepted level discards a partial count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_db      <= 1'b1;
      db_cnt      <= '0;
      press_cnt_o <= '0;
    end else begin
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_fire) begin
        db_cnt <= '0;
        btn_db <= btn_sync;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      if (db_fire && btn_db && press_cnt_o != 8'hff) begin
        press_cnt_o <= press_cnt_o + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLD:      state_nxt = WAIT_LOCK;
      WAIT_LOCK: if (run_ok) state_nxt = STRETCH;
      STRETCH: begin
        if (!run_ok) state_nxt = WAIT_LOCK;
        else if (st_cnt == ST_LAST) state_nxt = RUN;
      end
      RUN:       if (!run_ok) state_nxt = HOLD;
      default:   state_nxt = HOLD;
    endcase
  end

  // Output loaded from next state so it tracks the FSM edge-for-edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= HOLD;
      st_cnt     <= '0;
      soc_rst_no <= 1'b0;
    end else begin
      state      <= state_nxt;
      soc_rst_no <= (state_nxt == RUN);
      if (state == STRETCH && run_ok) st_cnt <= st_cnt + SW'(1);
      else st_cnt <= '0;
    end
  end

endmodule
